// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ADD/SUB/AND/OR ALU with accumulator and valid/ready handshake
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic             s1_use_acc_q, s1_use_acc_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             in_fire;
    logic             s2_load;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // S2 frees up either by being empty or by handing its beat to the sink this edge.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        op_a    = s1_use_acc_q ? acc_q : s1_a_q;
        sum     = {1'b0, op_a} + {1'b0, s1_b_q};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_ovf = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = op_a - s1_b_q;
                alu_ovf = (op_a < s1_b_q);
            end
            OP_AND: alu_res = op_a & s1_b_q;
            OP_OR:  alu_res = op_a | s1_b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_use_acc_d = s1_use_acc_q;
        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_a_d       = in_a;
            s1_b_d       = in_b;
            s1_op_d      = in_op;
            s1_use_acc_d = in_use_acc;
        end else if (s2_load) begin
            s1_valid_d   = 1'b0;
        end
    end

    // Accumulator follows S2 loads so a use_acc beat sitting in S1 sees its predecessor.
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        acc_d      = acc_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            res_d      = alu_res;
            ovf_d      = alu_ovf;
            zero_d     = (alu_res == '0);
            acc_d      = alu_res;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_ADD;
            s1_use_acc_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b1;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_use_acc_q <= s1_use_acc_d;
            s2_valid_q   <= s2_valid_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = res_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
    assign acc          = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - bench for alu_pipe: WIDTH 4/8/16 instances sharing stimulus, checked against a beat-level model
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_op;
    logic        in_use_acc;
    logic        out_ready;

    logic [2:0]       ir, ov, ovf_o, zero_o;
    logic [2:0][15:0] res_o, acc_o;
    logic [3:0]  r4, a4;
    logic [7:0]  r8, a8;
    logic [15:0] r16, a16;

    int checks;
    int failures;
    int edges;

    typedef struct {
        int               t;
        logic [2:0][15:0] res;
        logic [2:0]       ovf;
    } beat_t;

    beat_t            q[$];
    logic [2:0][15:0] macc;
    logic [2:0][15:0] last_res;
    logic [2:0]       last_ovf;

    alu_pipe #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_op(in_op), .in_use_acc(in_use_acc),
        .out_valid(ov[0]), .out_ready(out_ready), .out_result(r4),
        .out_overflow(ovf_o[0]), .out_zero(zero_o[0]), .acc(a4)
    );

    alu_pipe #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op), .in_use_acc(in_use_acc),
        .out_valid(ov[1]), .out_ready(out_ready), .out_result(r8),
        .out_overflow(ovf_o[1]), .out_zero(zero_o[1]), .acc(a8)
    );

    alu_pipe #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
        .out_valid(ov[2]), .out_ready(out_ready), .out_result(r16),
        .out_overflow(ovf_o[2]), .out_zero(zero_o[2]), .acc(a16)
    );

    assign res_o[0] = {12'd0, r4};
    assign res_o[1] = {8'd0, r8};
    assign res_o[2] = r16;
    assign acc_o[0] = {12'd0, a4};
    assign acc_o[1] = {8'd0, a8};
    assign acc_o[2] = a16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference ALU at width w, plain integer arithmetic.
    function automatic logic [16:0] alu_ref(input int w, input int unsigned a, input int unsigned b,
                                            input logic [1:0] op);
        int unsigned m;
        int unsigned r;
        logic        o;
        m = (32'd1 << w) - 32'd1;
        o = 1'b0;
        case (op)
            2'b00: begin r = a + b; o = ((r >> w) & 32'd1) != 0; r = r & m; end
            2'b01: begin r = (a - b) & m; o = (a < b); end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {o, r[15:0]};
    endfunction

    always @(negedge clk) begin
        logic       exp_ov;
        logic       exp_ir;
        beat_t      nb;
        logic [16:0] rr;
        int unsigned m, opa;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_in_ready w%0d", 4 << i), 32'(ir[i]), 32'd1);
                chk($sformatf("rst_out_valid w%0d", 4 << i), 32'(ov[i]), 32'd0);
                chk($sformatf("rst_result w%0d", 4 << i), 32'(res_o[i]), 32'd0);
                chk($sformatf("rst_ovf w%0d", 4 << i), 32'(ovf_o[i]), 32'd0);
                chk($sformatf("rst_zero w%0d", 4 << i), 32'(zero_o[i]), 32'd1);
                chk($sformatf("rst_acc w%0d", 4 << i), 32'(acc_o[i]), 32'd0);
            end
            q.delete();
            macc     = '0;
            last_res = '0;
            last_ovf = '0;
        end else begin
            exp_ov = (q.size() > 0) && (q[0].t < edges);
            exp_ir = (q.size() < 2) || out_ready;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("in_ready w%0d", 4 << i), 32'(ir[i]), 32'(exp_ir));
                chk($sformatf("out_valid w%0d", 4 << i), 32'(ov[i]), 32'(exp_ov));
                if (exp_ov) begin
                    chk($sformatf("result w%0d", 4 << i), 32'(res_o[i]), 32'(q[0].res[i]));
                    chk($sformatf("overflow w%0d", 4 << i), 32'(ovf_o[i]), 32'(q[0].ovf[i]));
                    chk($sformatf("zero w%0d", 4 << i), 32'(zero_o[i]), 32'(q[0].res[i] == 16'd0));
                    chk($sformatf("acc w%0d", 4 << i), 32'(acc_o[i]), 32'(q[0].res[i]));
                end else begin
                    chk($sformatf("hold_result w%0d", 4 << i), 32'(res_o[i]), 32'(last_res[i]));
                    chk($sformatf("hold_overflow w%0d", 4 << i), 32'(ovf_o[i]), 32'(last_ovf[i]));
                    chk($sformatf("hold_zero w%0d", 4 << i), 32'(zero_o[i]), 32'(last_res[i] == 16'd0));
                    chk($sformatf("hold_acc w%0d", 4 << i), 32'(acc_o[i]), 32'(last_res[i]));
                end
            end
            if (exp_ov && out_ready) begin
                last_res = q[0].res;
                last_ovf = q[0].ovf;
                void'(q.pop_front());
            end
            // Results are fixed in acceptance order: use_acc takes the previous beat's result.
            if (in_valid && ir[2]) begin
                nb.t = edges + 1;
                for (int i = 0; i < 3; i++) begin
                    m   = (32'd1 << (4 << i)) - 32'd1;
                    opa = in_use_acc ? 32'(macc[i]) : (32'(in_a) & m);
                    rr  = alu_ref(4 << i, opa, 32'(in_b) & m, in_op);
                    nb.res[i] = rr[15:0];
                    nb.ovf[i] = rr[16];
                    macc[i]   = rr[15:0];
                end
                q.push_back(nb);
            end
            edges++;
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic ua);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_op      = op;
        in_use_acc = ua;
    endtask

    task automatic single4(input string nm, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           input logic [3:0] er, input logic eo, input logic ez);
        @(posedge clk); #1;
        drive({12'd0, a}, {12'd0, b}, op, 1'b0);
        #1 chk({nm, "_ready"}, 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk({nm, "_latency"}, 32'(ov[0]), 32'd0);
        @(posedge clk); #2;
        chk({nm, "_valid"}, 32'(ov[0]), 32'd1);
        chk({nm, "_result"}, 32'(r4), 32'(er));
        chk({nm, "_ovf"}, 32'(ovf_o[0]), 32'(eo));
        chk({nm, "_zero"}, 32'(zero_o[0]), 32'(ez));
    endtask

    initial begin
        int   sent;
        int   cyc;
        logic fired;
        checks = 0; failures = 0; edges = 0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_use_acc = 1'b0;
        out_ready = 1'b1;
        macc = '0; last_res = '0; last_ovf = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        single4("add", 4'b0100, 4'b0011, 2'b00, 4'b0111, 1'b0, 1'b0);
        single4("sub", 4'b1010, 4'b0100, 2'b01, 4'b0110, 1'b0, 1'b0);
        single4("and", 4'b1010, 4'b1100, 2'b10, 4'b1000, 1'b0, 1'b0);
        single4("or",  4'b1010, 4'b1100, 2'b11, 4'b1110, 1'b0, 1'b0);
        single4("add_wrap", 4'hF, 4'h1, 2'b00, 4'h0, 1'b1, 1'b1);
        single4("sub_wrap", 4'h3, 4'h5, 2'b01, 4'hE, 1'b1, 1'b0);

        // Accumulator chain, checked on the 8-bit instance.
        @(posedge clk); #1;
        drive(16'd10, 16'd5, 2'b00, 1'b0);
        #1 chk("chain_ready1", 32'(ir[1]), 32'd1);
        @(posedge clk); #1;
        drive(16'd0, 16'd20, 2'b00, 1'b1);
        #1 chk("chain_ready2", 32'(ir[1]), 32'd1);
        @(posedge clk); #1;
        drive(16'd0, 16'd35, 2'b01, 1'b1);
        #1 chk("chain_ready3", 32'(ir[1]), 32'd1);
        chk("chain_res1", 32'(r8), 32'd15);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("chain_res2", 32'(r8), 32'd35);
        chk("chain_valid2", 32'(ov[1]), 32'd1);
        @(posedge clk); #2;
        chk("chain_res3", 32'(r8), 32'd0);
        chk("chain_zero3", 32'(zero_o[1]), 32'd1);
        chk("chain_acc", 32'(a8), 32'd0);
        @(posedge clk);

        // Backpressure: three beats against a stalled sink.
        #1 out_ready = 1'b0;
        drive(16'd1, 16'd2, 2'b00, 1'b0);
        #1 chk("bp_ready1", 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        drive(16'd5, 16'd6, 2'b00, 1'b0);
        #1 chk("bp_ready2", 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        drive(16'd7, 16'd8, 2'b11, 1'b0);
        #1 chk("bp_full", 32'(ir[0]), 32'd0);
        repeat (2) begin
            @(posedge clk); #2;
            chk("bp_hold", 32'(ir[0]), 32'd0);
            chk("bp_head", 32'(r4), 32'd3);
        end
        #1 out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("bp_drain2", 32'(r4), 32'd11);
        @(posedge clk); #2;
        chk("bp_drain3", 32'(r4), 32'd15);
        @(posedge clk); #2;
        chk("bp_empty", 32'(ov[0]), 32'd0);

        // Reset with two beats in flight.
        #1 out_ready = 1'b0;
        drive(16'd2, 16'd3, 2'b00, 1'b0);
        @(posedge clk); #1;
        drive(16'd4, 16'd1, 2'b01, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("arst_out_valid", 32'(ov[0]), 32'd0);
        chk("arst_acc", 32'(a4), 32'd0);
        chk("arst_in_ready", 32'(ir[0]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
            chk("arst_no_stale", 32'(ov[0]), 32'd0);
        end

        // Random traffic.
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || in_valid) && cyc < 60000) begin
            @(negedge clk);
            fired = in_valid && ir[2];
            @(posedge clk); #1;
            cyc++;
            if (!in_valid || fired) begin
                in_valid = 1'b0;
                if (sent < 10000 && $urandom_range(0, 9) < 7) begin
                    drive(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                    sent++;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        chk("random_beats_sent", 32'(sent), 32'd10000);
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
